// File: rtl/freq_counter_mc_if.sv
// Handshake/result bundle for the multi-channel frequency counter.
// The master side drives the measured signals and the acknowledge; the slave side (the counter) returns results.
interface freq_counter_mc_if #(
  parameter int CH     = 4,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 24
);
  logic [CH-1:0]       fin;
  logic                enable;
  logic [GATE_W-1:0]   gate_len;
  logic [1:0]          edge_mode;
  logic                res_ack;
  logic [CH*CNT_W-1:0] res_data;
  logic [CH-1:0]       res_ovf;
  logic                res_valid;
  logic                overrun;
  logic                busy;

  modport master (
    output fin, enable, gate_len, edge_mode, res_ack,
    input  res_data, res_ovf, res_valid, overrun, busy
  );

  modport slave (
    input  fin, enable, gate_len, edge_mode, res_ack,
    output res_data, res_ovf, res_valid, overrun, busy
  );
endinterface

// File: rtl/freq_counter_mc.sv
// Multi-channel gated edge counter: synchronises each fin bit, counts selected edges over a
// programmable gate window and hands saturating per-channel counts to a consumer.
module freq_counter_mc #(
  parameter int CH          = 4,
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  freq_counter_mc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t                   state;
  logic [CH-1:0]            fin_sync [SYNC_STAGES];
  logic [CH-1:0]            fin_hist;
  logic [CH-1:0]            rise;
  logic [CH-1:0]            fall;
  logic [CH-1:0]            hit;
  logic                     start_gate;
  logic [1:0]               mode_q;
  logic [GATE_W-1:0]        timer;
  logic [CH-1:0][CNT_W-1:0] cnt;
  logic [CH-1:0]            ovf;
  logic [CH*CNT_W-1:0]      res_data_q;
  logic [CH-1:0]            res_ovf_q;
  logic                     res_valid_q;
  logic                     overrun_q;
  logic                     busy_q;

  function automatic logic [GATE_W-1:0] gate_load(input logic [GATE_W-1:0] len);
    return (len == '0) ? GATE_W'(1) : len;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Mode 2'b11 deliberately falls through to rising-edge counting.
  function automatic logic [CH-1:0] edge_sel(input logic [1:0]    mode,
                                             input logic [CH-1:0] r,
                                             input logic [CH-1:0] f);
    case (mode)
      2'b01:   return f;
      2'b10:   return r | f;
      default: return r;
    endcase
  endfunction

  // Input synchroniser chain plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) fin_sync[s] <= '0;
      fin_hist <= '0;
    end else begin
      fin_sync[0] <= bus.fin;
      for (int s = 1; s < SYNC_STAGES; s++) fin_sync[s] <= fin_sync[s-1];
      fin_hist <= fin_sync[SYNC_STAGES-1];
    end
  end

  assign rise       = fin_sync[SYNC_STAGES-1] & ~fin_hist;
  assign fall       = ~fin_sync[SYNC_STAGES-1] & fin_hist;
  assign hit        = edge_sel(mode_q, rise, fall);
  assign start_gate = bus.enable && ((state == IDLE) || (state == LATCH));

  // Measurement control, counters and result hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= '0;
      timer       <= '0;
      cnt         <= '0;
      ovf         <= '0;
      res_data_q  <= '0;
      res_ovf_q   <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (res_valid_q && bus.res_ack) res_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.enable) begin
            state  <= GATE;
            busy_q <= 1'b1;
          end
        end
        GATE: begin
          for (int c = 0; c < CH; c++) begin
            if (hit[c]) begin
              if (&cnt[c]) ovf[c] <= 1'b1;
              cnt[c] <= sat_inc(cnt[c]);
            end
          end
          timer <= timer - GATE_W'(1);
          if (timer == GATE_W'(1)) state <= LATCH;
        end
        LATCH: begin
          res_data_q  <= cnt;
          res_ovf_q   <= ovf;
          res_valid_q <= 1'b1;
          overrun_q   <= res_valid_q && !bus.res_ack;
          if (bus.enable) begin
            state <= GATE;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase

      // Gate parameters are frozen here so mid-gate input changes wait for the next gate.
      if (start_gate) begin
        timer  <= gate_load(bus.gate_len);
        mode_q <= bus.edge_mode;
        cnt    <= '0;
        ovf    <= '0;
      end
    end
  end

  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_valid = res_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_freq_counter_mc.sv
// Scoreboarded bench for freq_counter_mc: a window-based edge-count model predicts each latched
// result; a monitor pops predictions whenever the DUT presents a new result.
module tb_freq_counter_mc;
  localparam int CH     = 4;
  localparam int CNT_W  = 4;
  localparam int GATE_W = 24;
  localparam int SS     = 2;
  localparam int MAXK   = 20000;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CH*CNT_W-1:0] data;
    logic [CH-1:0]       ovf;
    logic                ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  freq_counter_mc_if #(.CH(CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) bus ();

  freq_counter_mc #(.CH(CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model state
  logic [CH-1:0] samp [MAXK];
  int            k = 0;
  int            m_st = 0;   // 0 idle, 1 gate, 2 latch
  int            m_e = 0;
  int            m_n = 1;
  logic [1:0]    m_mode = 2'b00;
  logic          m_valid = 1'b0;

  // fin generator control
  int   half [CH];
  logic fin_rand = 1'b0;
  logic fin_restart = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] smp(input int j);
    if (j < 1 || j >= MAXK) return '0;
    return samp[j];
  endfunction

  // Count matching transitions among the samples that reach the edge detector during the gate window.
  function automatic exp_t predict(input int e, input int n, input logic [1:0] mode, input logic ovr);
    exp_t r;
    r.data = '0;
    r.ovf  = '0;
    r.ovr  = ovr;
    for (int c = 0; c < CH; c++) begin
      int cnt_c;
      cnt_c = 0;
      for (int j = e - SS + 1; j <= e + n - SS; j++) begin
        logic [CH-1:0] a, b;
        a = smp(j - 1);
        b = smp(j);
        case (mode)
          2'b01:   if (a[c] && !b[c]) cnt_c++;
          2'b10:   if (a[c] != b[c]) cnt_c++;
          default: if (!a[c] && b[c]) cnt_c++;
        endcase
      end
      if (cnt_c > CMAX) begin
        r.ovf[c] = 1'b1;
        cnt_c = CMAX;
      end
      r.data[c*CNT_W +: CNT_W] = CNT_W'(cnt_c);
    end
    return r;
  endfunction

  // Behavioural model, stepped on each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0; m_st = 0; m_valid = 1'b0;
      end else begin
        logic pv, ack, en;
        k++;
        if (k < MAXK) samp[k] = bus.fin;
        pv  = m_valid;
        ack = bus.res_ack;
        en  = bus.enable;
        if (pv && ack) m_valid = 1'b0;
        case (m_st)
          0: if (en) begin
            m_st = 1; m_e = k; m_n = (bus.gate_len == 0) ? 1 : int'(bus.gate_len); m_mode = bus.edge_mode;
          end
          1: if (k == m_e + m_n) m_st = 2;
          default: begin
            sb.push_back(predict(m_e, m_n, m_mode, pv && !ack));
            m_valid = 1'b1;
            if (en) begin
              m_st = 1; m_e = k; m_n = (bus.gate_len == 0) ? 1 : int'(bus.gate_len); m_mode = bus.edge_mode;
            end else m_st = 0;
          end
        endcase
      end
    end
  end

  // Monitor: a new result is visible when res_valid rises, survives an ack, or comes with overrun
  initial begin
    logic pv, pa, ev;
    exp_t e;
    pv = 1'b0; pa = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; pa = 1'b0;
      end else begin
        check("busy", bus.busy, (m_st != 0));
        ev = bus.res_valid && (!pv || pa || bus.overrun);
        if (ev) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_result: got data %0h, none expected at %0t", bus.res_data, $time);
          end else begin
            e = sb.pop_front();
            check("res_data", bus.res_data, e.data);
            check("res_ovf", bus.res_ovf, e.ovf);
            check("overrun", bus.overrun, e.ovr);
          end
        end else if (bus.overrun) begin
          n_chk++; n_fail++;
          $display("FAIL stray_overrun: got 1 expected 0 at %0t", $time);
        end
        pv = bus.res_valid;
        pa = bus.res_ack;
      end
    end
  end

  // fin stimulus: either per-channel square waves or random toggling
  initial begin
    logic [CH-1:0] fin_v;
    int ph [CH];
    fin_v = '0;
    for (int c = 0; c < CH; c++) ph[c] = 0;
    bus.fin = '0;
    forever begin
      @(posedge clk);
      #2;
      if (fin_restart) begin
        fin_v = '0;
        for (int c = 0; c < CH; c++) ph[c] = 0;
        fin_restart = 1'b0;
      end else if (fin_rand) begin
        for (int c = 0; c < CH; c++) if ($urandom_range(0, 3) == 0) fin_v[c] = ~fin_v[c];
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (half[c] != 0) begin
            ph[c]++;
            if (ph[c] >= half[c]) begin
              fin_v[c] = ~fin_v[c];
              ph[c] = 0;
            end
          end
        end
      end
      bus.fin = fin_v;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic run_one(input logic [1:0] mode, input int ch, input int half_v,
                         input int exp_v, input logic exp_o, input string name);
    logic [CH*CNT_W-1:0] ed;
    logic [CH-1:0]       eo;
    int t;
    for (int c = 0; c < CH; c++) half[c] = 0;
    half[ch] = half_v;
    fin_restart = 1'b1;
    cyc(20);
    bus.gate_len = 100; bus.edge_mode = mode; bus.enable = 1'b1;
    cyc(1);
    bus.enable = 1'b0; bus.gate_len = 7; bus.edge_mode = ~mode;
    t = 0;
    while (!bus.res_valid && t < 400) begin
      cyc(1);
      t++;
    end
    if (t >= 400) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no res_valid expected res_valid within 400 cycles", name);
    end else begin
      ed = '0; eo = '0;
      ed[ch*CNT_W +: CNT_W] = CNT_W'(exp_v);
      eo[ch] = exp_o;
      check({name, "_data"}, bus.res_data, ed);
      check({name, "_ovf"}, bus.res_ovf, eo);
    end
    bus.res_ack = 1'b1;
    cyc(1);
    bus.res_ack = 1'b0;
    cyc(2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CH; c++) half[c] = 0;
    bus.enable = 1'b0; bus.gate_len = '0; bus.edge_mode = 2'b00; bus.res_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_ovf", bus.res_ovf, 0);
    #1 rst_n = 1'b1;
    cyc(5);

    run_one(2'b00, 0, 5, 10, 1'b0, "rise_p10");
    run_one(2'b01, 0, 5, 10, 1'b0, "fall_p10");
    run_one(2'b10, 0, 5, CMAX, 1'b1, "both_p10");
    run_one(2'b11, 0, 5, 10, 1'b0, "mode3_p10");
    run_one(2'b00, 1, 2, CMAX, 1'b1, "sat_ch1_p4");

    // back-to-back gates without acknowledge, then with acknowledge held
    fin_rand = 1'b1;
    bus.gate_len = 20; bus.edge_mode = 2'b10; bus.enable = 1'b1;
    cyc(70);
    bus.enable = 1'b0;
    cyc(30);
    bus.res_ack = 1'b1;
    bus.gate_len = 15; bus.enable = 1'b1;
    cyc(60);
    bus.enable = 1'b0;
    cyc(25);
    bus.res_ack = 1'b0;

    // single-cycle gates
    bus.gate_len = 0; bus.edge_mode = 2'b00; bus.enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.res_ack = ($urandom_range(0, 1) == 1);
      cyc(1);
    end
    bus.enable = 1'b0; bus.res_ack = 1'b1;
    cyc(6);
    bus.res_ack = 1'b0;

    // reset in the middle of a gate
    bus.gate_len = 50; bus.enable = 1'b1;
    cyc(1);
    bus.enable = 1'b0;
    cyc(10);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_overrun", bus.overrun, 0);
    check("midrst_res_data", bus.res_data, 0);
    check("midrst_res_ovf", bus.res_ovf, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    cyc(80);
    check("midrst_no_result", bus.res_valid, 0);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bus.gate_len = GATE_W'($urandom_range(0, 12));
      bus.edge_mode = 2'($urandom_range(0, 3));
      bus.res_ack = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    bus.enable = 1'b0; bus.res_ack = 1'b1;
    cyc(40);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/freq_counter_mc.md
FREQ_COUNTER_MC -- requirements
Module: freq_counter_mc

Interface
REQ-001 Parameter CH, default 4, number of independent input channels.
REQ-002 Parameter CNT_W, default 16, per-channel count width.
REQ-003 Parameter GATE_W, default 24, gate-length width.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth; legal range 2-4.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 fin  input  CH  asynchronous signals to be measured, bit i = channel i.
REQ-008 enable  input  1  level; 1 = run measurements back-to-back.
REQ-009 gate_len  input  GATE_W  gate length in clk cycles.
REQ-010 edge_mode  input  2  00 rising, 01 falling, 10 both, 11 treated as rising.
REQ-011 res_ack  input  1  consumer acknowledge of current result.
REQ-012 res_data  output  CH*CNT_W  latched counts; channel i at bits [i*CNT_W +: CNT_W].
REQ-013 res_ovf  output  CH  latched per-channel saturation flags.
REQ-014 res_valid  output  1  result held and unacknowledged.
REQ-015 overrun  output  1  one-cycle pulse: unacknowledged result overwritten.
REQ-016 busy  output  1  high in GATE and LATCH states.

Function
REQ-017 Each fin bit SHALL pass through SYNC_STAGES flops plus one history flop; edge detected by comparing last sync stage with history flop.
REQ-018 Detection latency SHALL be SYNC_STAGES+1 clk cycles from the sampling edge capturing the fin transition.
REQ-019 FSM states IDLE, GATE, LATCH.
REQ-020 IDLE: busy=0; enable=1 -> GATE next cycle; gate_len and edge_mode sampled on that transition and held for the measurement.
REQ-021 On GATE entry all channel counters SHALL clear to 0 and the gate timer SHALL load max(gate_len,1).
REQ-022 GATE SHALL last exactly max(gate_len,1) cycles; an edge matching sampled edge_mode, detected in a GATE cycle, increments that channel's counter by 1.
REQ-023 Counter at 2^CNT_W-1 SHALL hold (saturate) and set the channel's ovf flag; ovf clears only on GATE entry.
REQ-024 LATCH SHALL last one cycle; edges detected in LATCH are not counted; counters and ovf flags copied into res_data/res_ovf; res_valid set.
REQ-025 From LATCH: enable=1 -> GATE (new measurement), enable=0 -> IDLE.
REQ-026 Deasserting enable during GATE SHALL NOT abort; measurement completes and latches.
REQ-027 res_valid SHALL clear the cycle after a cycle with res_valid=1 and res_ack=1; res_ack with res_valid=0 ignored.
REQ-028 LATCH while res_valid=1 and res_ack=0 SHALL overwrite results and pulse overrun for one cycle.
REQ-029 LATCH coinciding with res_ack=1 SHALL load new data, keep res_valid=1, no overrun.
REQ-030 gate_len changes during GATE SHALL have no effect until next GATE entry.

Reset
REQ-031 rst_n low SHALL immediately force IDLE and clear sync/history flops, counters, timer, res_data, res_ovf, res_valid, overrun and busy to 0.
REQ-032 Reset mid-GATE SHALL discard the measurement; no result produced.
REQ-033 fin high at reset release MAY be counted as one rising edge in the first gate.

Verification
REQ-034 CH=4, gate_len=100, rising, fin[0] period 10 clk, others static -> res_data ch0=10, ch1-3=0, res_valid=1 after 100 GATE cycles + LATCH.
REQ-035 Same stimulus, edge_mode=10 -> ch0=20; edge_mode=01 -> ch0=10.
REQ-036 CNT_W=4, gate_len=100, fin[1] period 4 -> ch1=15, res_ovf[1]=1, other ovf bits 0.
REQ-037 enable held, res_ack never asserted -> second LATCH pulses overrun once, res_valid stays 1; ack in LATCH cycle -> no overrun.
REQ-038 gate_len=0 -> one-cycle GATE; rst_n pulsed mid-GATE -> all outputs 0, state IDLE, no res_valid.
